// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, alignment state encoding and the
// 10b-to-8b data decode used by the receive channel (tokens shared with the encoder).
package tmds_pkg;

   localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      ALIGN_SEARCH = 2'd0,
      ALIGN_SLIP   = 2'd1,
      ALIGN_LOCKED = 2'd2
   } align_state_e;

   // Bit 9 undoes the optional inversion, bit 8 selects XOR or XNOR chaining.
   function automatic logic [7:0] tmds_decode_sym(input logic [9:0] sym);
      logic [7:0] t;
      logic [7:0] o;
      t    = sym[9] ? ~sym[7:0] : sym[7:0];
      o    = '0;
      o[0] = t[0];
      for (int i = 1; i < 8; i++) begin
         o[i] = sym[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
      end
      return o;
   endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-alignment tracker: counts control-token runs, requests deserializer bit-slips
// while searching and reports lock until tokens stop arriving for too long.
module tmds_align_fsm
   import tmds_pkg::*;
#(
   parameter int LOCK_RUN       = 8,
   parameter int SEARCH_TIMEOUT = 2048,
   parameter int SLIP_SETTLE    = 16,
   parameter int LOSS_TIMEOUT   = 16384
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sym_valid_i,
   input  logic is_token_i,
   output logic bitslip_o,
   output logic locked_o
);

   localparam int RUN_W    = $clog2(LOCK_RUN + 1);
   localparam int SRCH_W   = $clog2(SEARCH_TIMEOUT + 1);
   localparam int SETTLE_W = $clog2(SLIP_SETTLE + 1);
   localparam int GAP_W    = $clog2(LOSS_TIMEOUT + 1);

   localparam logic [RUN_W-1:0]    RUN_MAX     = RUN_W'(LOCK_RUN);
   localparam logic [SRCH_W-1:0]   SRCH_MAX    = SRCH_W'(SEARCH_TIMEOUT);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE - 1);
   localparam logic [GAP_W-1:0]    GAP_MAX     = GAP_W'(LOSS_TIMEOUT);

   localparam logic [1:0] ST_SEARCH = ALIGN_SEARCH;
   localparam logic [1:0] ST_SLIP   = ALIGN_SLIP;
   localparam logic [1:0] ST_LOCKED = ALIGN_LOCKED;

   logic [1:0]          state_q,   state_d;
   logic [RUN_W-1:0]    run_q,     run_d;
   logic [SRCH_W-1:0]   srch_q,    srch_d;
   logic [SETTLE_W-1:0] settle_q,  settle_d;
   logic [GAP_W-1:0]    gap_q,     gap_d;
   logic                bitslip_q, bitslip_d;
   logic                locked_q,  locked_d;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      srch_d    = srch_q;
      settle_d  = settle_q;
      gap_d     = gap_q;
      bitslip_d = 1'b0;
      locked_d  = locked_q;

      if (sym_valid_i && state_q != ST_SLIP) begin
         if (!is_token_i)          run_d = '0;
         else if (run_q != RUN_MAX) run_d = run_q + 1'b1;
      end

      case (state_q)
         ST_SEARCH: begin
            if (sym_valid_i) begin
               srch_d = srch_q + 1'b1;
               // A completed token run takes priority over a coincident timeout.
               if (run_d == RUN_MAX) begin
                  state_d  = ST_LOCKED;
                  locked_d = 1'b1;
                  srch_d   = '0;
                  gap_d    = '0;
               end else if (srch_d == SRCH_MAX) begin
                  state_d   = ST_SLIP;
                  bitslip_d = 1'b1;
                  run_d     = '0;
                  srch_d    = '0;
                  settle_d  = '0;
               end
            end
         end
         ST_SLIP: begin
            if (settle_q == SETTLE_LAST) begin
               state_d  = ST_SEARCH;
               settle_d = '0;
               run_d    = '0;
               srch_d   = '0;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (sym_valid_i) begin
               gap_d = is_token_i ? '0 : gap_q + 1'b1;
               if (gap_d == GAP_MAX) begin
                  state_d  = ST_SEARCH;
                  locked_d = 1'b0;
                  run_d    = '0;
                  srch_d   = '0;
                  gap_d    = '0;
               end
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   // NOTE: state registers use non-blocking assignments; the next-state logic above is blocking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SEARCH;
         run_q     <= '0;
         srch_q    <= '0;
         settle_q  <= '0;
         gap_q     <= '0;
         bitslip_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         srch_q    <= srch_d;
         settle_q  <= settle_d;
         gap_q     <= gap_d;
         bitslip_q <= bitslip_d;
         locked_q  <= locked_d;
      end
   end

   assign bitslip_o = bitslip_q;
   assign locked_o  = locked_q;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS 10b-to-8b channel decoder: two-stage decode pipeline (classify, then decode)
// feeding a word-alignment tracker that drives the deserializer bit-slip request.
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int LOCK_RUN       = 8,
   parameter int SEARCH_TIMEOUT = 2048,
   parameter int SLIP_SETTLE    = 16,
   parameter int LOSS_TIMEOUT   = 16384
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sym_valid,
   input  logic [9:0] sym_in,
   output logic       data_valid,
   output logic [7:0] data_out,
   output logic       de,
   output logic [1:0] ctrl,
   output logic       bitslip,
   output logic       locked
);

   logic       is_token;
   logic [1:0] token_ctrl;

   always_comb begin
      is_token   = 1'b1;
      token_ctrl = 2'b00;
      case (sym_in)
         CTRL_TOKEN_00: token_ctrl = 2'b00;
         CTRL_TOKEN_01: token_ctrl = 2'b01;
         CTRL_TOKEN_10: token_ctrl = 2'b10;
         CTRL_TOKEN_11: token_ctrl = 2'b11;
         default:       is_token   = 1'b0;
      endcase
   end

   logic       s1_valid_q;
   logic [9:0] s1_sym_q;
   logic       s1_token_q;
   logic [1:0] s1_ctrl_q;

   // Stage contents only move on valid symbols; the valid flags themselves always advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sym_q   <= '0;
         s1_token_q <= 1'b0;
         s1_ctrl_q  <= '0;
      end else begin
         s1_valid_q <= sym_valid;
         if (sym_valid) begin
            s1_sym_q   <= sym_in;
            s1_token_q <= is_token;
            s1_ctrl_q  <= token_ctrl;
         end
      end
   end

   logic       s2_valid_q;
   logic [7:0] s2_data_q;
   logic       s2_de_q;
   logic [1:0] s2_ctrl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_de_q    <= 1'b0;
         s2_ctrl_q  <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_de_q   <= ~s1_token_q;
            s2_data_q <= s1_token_q ? 8'h00 : tmds_decode_sym(s1_sym_q);
            if (s1_token_q) s2_ctrl_q <= s1_ctrl_q;
         end
      end
   end

   tmds_align_fsm #(
      .LOCK_RUN       (LOCK_RUN),
      .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
      .SLIP_SETTLE    (SLIP_SETTLE),
      .LOSS_TIMEOUT   (LOSS_TIMEOUT)
   ) u_align (
      .clk         (clk),
      .rst_n       (rst_n),
      .sym_valid_i (s1_valid_q),
      .is_token_i  (s1_token_q),
      .bitslip_o   (bitslip),
      .locked_o    (locked)
   );

   assign data_valid = s2_valid_q;
   assign data_out   = s2_data_q;
   assign de         = s2_de_q;
   assign ctrl       = s2_ctrl_q;

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
TMDS (DVI/HDMI) 10b-to-8b channel decoder. It is the receive-side counterpart of the team's TMDS encoder.
- Accepts parallel 10-bit symbols from a deserializer.
- Recovers 8-bit pixel data, DE and the two control bits.
- Runs a word-alignment state machine that requests deserializer bit-slips until control tokens are found on symbol boundaries.
- One instance per TMDS channel (three per link), sitting between the deserializer and the pixel-format logic.

Parameters:
LOCK_RUN, 8, consecutive control tokens required to declare alignment
SEARCH_TIMEOUT, 2048, valid symbols in SEARCH without a qualifying run before a bit-slip is requested
SLIP_SETTLE, 16, clock cycles ignored after a bit-slip pulse
LOSS_TIMEOUT, 16384, valid symbols in LOCKED without any control token before lock is dropped

Ports:
clk  input  1  symbol clock
rst_n  input  1  asynchronous active-low reset
sym_valid  input  1  sym_in carries a new symbol this cycle
sym_in  input  10  received symbol; bit 0 is first on the wire
data_valid  output  1  data_out/de/ctrl qualified, 2 cycles after sym_valid
data_out  output  8  decoded pixel byte; 0 when de=0
de  output  1  1 = data symbol, 0 = control token
ctrl  output  2  {c1,c0} from the last control token; held during data periods
bitslip  output  1  one-cycle request to the deserializer to shift by one bit
locked  output  1  word alignment established

Behaviour:
Reset and timing
- Reset is asynchronous assert, synchronous deassert. All outputs reset to 0; FSM resets to SEARCH; all counters reset to 0.
- Fixed 2-cycle pipeline: stage 1 registers the symbol and token classification; stage 2 registers the decoded outputs.
- data_valid is sym_valid delayed by 2 cycles. No backpressure.
- Cycles with sym_valid=0 do not advance pipeline contents or any symbol counter.

Token classification (sym[9:0])
- 1101010100 -> ctrl=00
- 0010101011 -> ctrl=01
- 0101010100 -> ctrl=10
- 1010101011 -> ctrl=11
- Token: de=0, data_out=0, ctrl updated.
- Any other symbol: de=1, ctrl held, decoded as below.

Data decode
- t = sym[9] ? ~sym[7:0] : sym[7:0]
- out[0] = t[0]
- out[i] = sym[8] ? t[i]^t[i-1] : ~(t[i]^t[i-1]), for i = 1..7
- Decoding is performed whether or not locked; only the locked flag reflects alignment.

Alignment FSM (states SEARCH, SLIP, LOCKED)
- run_cnt: increments on each valid token; clears on a valid non-token; saturates at LOCK_RUN.
- SEARCH:
  - run_cnt reaching LOCK_RUN -> LOCKED.
  - Otherwise srch_cnt counts valid symbols; at SEARCH_TIMEOUT -> pulse bitslip for 1 cycle, clear counters, go to SLIP.
  - If both conditions occur on the same symbol, LOCKED wins and no slip is issued.
- SLIP:
  - Wait SLIP_SETTLE clocks, counted regardless of sym_valid, ignoring symbols.
  - Then clear run_cnt and srch_cnt and return to SEARCH.
- LOCKED:
  - locked=1, registered and asserted the cycle after the transition.
  - gap_cnt counts valid non-token symbols and clears on any valid token.
  - gap_cnt reaching LOSS_TIMEOUT -> locked=0 next cycle, clear counters, go to SEARCH.
  - No bitslip is issued in LOCKED.
- Counter widths: $clog2(param+1); counters never wrap.
- Asserting rst_n low mid-operation (including in SLIP with a pulse pending) aborts immediately, with no bitslip emitted.

Decomposition:
- Shared package tmds_pkg holds:
  - the four control-token constants (CTRL_TOKEN_00..11);
  - an align-state enum typedef;
  - a function decoding a 10-bit symbol to the 8-bit value.
- The encoder shares the same token constants.
- One natural sub-module: tmds_align_fsm, containing the counters, FSM and the bitslip/locked outputs. It is fed a per-symbol is_token strobe from the decode datapath.

Test Plan:
1. Reset, then valid sym 0x100 -> 2 cycles later data_valid=1, de=1, data_out=0x00. Sym 0x2FF -> data_out=0xFE, de=1.
2. Valid sym 0x354 (1101010100) -> de=0, ctrl=00, data_out=0. Then 0x0AB -> ctrl=01; 0x154 -> ctrl=10; 0x2AB -> ctrl=11. A following data symbol leaves ctrl=11.
3. 8 consecutive 0x354 symbols -> locked=1 the cycle after the 8th reaches the FSM. Seven tokens then one data symbol then seven tokens -> locked stays 0.
4. Continuous data symbols from reset -> bitslip pulses once after 2048 valid symbols; no symbol is counted for 16 cycles; the next pulse comes 2048 valid symbols later. With sym_valid=0 in between, the pulse is delayed accordingly.
5. Drive a bit-rotated token stream and model the slip in the bench -> lock after the required number of slips; then 16384 data symbols with no token -> locked falls to 0 and searching resumes.
6. Assert rst_n low during SLIP and during a burst with data_valid=1 -> all outputs 0 immediately. After release, first data_valid appears 2 cycles after the first sym_valid.
